// File: rtl/rob_pkg.sv
// rob_pkg: shared constants, tag type and entry layout for the reorder buffer.
package rob_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_PREG_W = 7;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  rd_wen;
    logic [ROB_PREG_W-1:0] pd_old;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatch, completion, commit and status signals of the reorder buffer.
// The master side (dispatch/FUs) drives requests; the slave side is the buffer itself.
interface reorder_buffer_if import rob_pkg::*; #(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = $clog2(DEPTH),
  parameter int PREG_W = ROB_PREG_W
);
  logic              alloc_valid_in;
  logic              alloc_ready_out;
  logic [PREG_W-1:0] alloc_pd_old;
  logic              alloc_rd_wen;
  logic [TAG_W-1:0]  alloc_tag_out;
  logic              alu_done_valid;
  logic              b_done_valid;
  logic              mem_done_valid;
  logic [TAG_W-1:0]  alu_done_tag;
  logic [TAG_W-1:0]  b_done_tag;
  logic [TAG_W-1:0]  mem_done_tag;
  logic              b_mispredict;
  logic              commit_valid_out;
  logic [TAG_W-1:0]  commit_tag_out;
  logic              commit_free_out;
  logic [PREG_W-1:0] commit_pd_old;
  logic [TAG_W-1:0]  curr_rob_tag;
  logic              empty_out;
  logic              full_out;
  logic [31:0]       perf_commit_cnt;
  logic [31:0]       perf_flush_cnt;
  modport master (
    output alloc_valid_in, alloc_pd_old, alloc_rd_wen,
    output alu_done_valid, b_done_valid, mem_done_valid,
    output alu_done_tag, b_done_tag, mem_done_tag, b_mispredict,
    input  alloc_ready_out, alloc_tag_out,
    input  commit_valid_out, commit_tag_out, commit_free_out, commit_pd_old,
    input  curr_rob_tag, empty_out, full_out, perf_commit_cnt, perf_flush_cnt
  );
  modport slave (
    input  alloc_valid_in, alloc_pd_old, alloc_rd_wen,
    input  alu_done_valid, b_done_valid, mem_done_valid,
    input  alu_done_tag, b_done_tag, mem_done_tag, b_mispredict,
    output alloc_ready_out, alloc_tag_out,
    output commit_valid_out, commit_tag_out, commit_free_out, commit_pd_old,
    output curr_rob_tag, empty_out, full_out, perf_commit_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/rob_perf_counters.sv
// rob_perf_counters: 32-bit wrapping commit and flush event counters.
module rob_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        commit_i,
  input  logic        flush_i,
  output logic [31:0] commit_cnt_o,
  output logic [31:0] flush_cnt_o
);
  logic [31:0] commit_cnt_q, commit_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    commit_cnt_d = commit_cnt_q + 32'(commit_i);
    flush_cnt_d = flush_cnt_q + 32'(flush_i);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      commit_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      commit_cnt_q <= commit_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign commit_cnt_o = commit_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement tracker with mispredict squash; reset is sync active-low.
// Define ROB_PERF_EN to add commit/flush performance counters.
module reorder_buffer import rob_pkg::*; #(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = $clog2(DEPTH),
  parameter int PREG_W = ROB_PREG_W
) (
  input logic             clk,
  input logic             reset,
  reorder_buffer_if.slave rob
);
  rob_entry_t       mem_q [DEPTH];
  rob_entry_t       mem_d [DEPTH];
  rob_entry_t       head_e;
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, b_off;
  logic [TAG_W:0]   count_q, count_d;
  logic             flush, alloc_fire, commit;
  assign head_e = mem_q[head_q];
  assign flush = rob.b_done_valid & rob.b_mispredict;
  assign rob.alloc_ready_out = reset & ~count_q[TAG_W] & ~flush;
  assign alloc_fire = rob.alloc_valid_in & rob.alloc_ready_out;
  assign commit = reset & head_e.valid & head_e.done;
  assign b_off = rob.b_done_tag - head_q;
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].valid && ((rob.alu_done_valid && rob.alu_done_tag == TAG_W'(i)) ||
                             (rob.b_done_valid && rob.b_done_tag == TAG_W'(i)) ||
                             (rob.mem_done_valid && rob.mem_done_tag == TAG_W'(i))))
        mem_d[i].done = 1'b1;
      // age is distance from head, so squash overrides same-cycle completions
      if (flush && TAG_W'(TAG_W'(i) - head_q) > b_off)
        mem_d[i] = '0;
    end
    if (commit)
      mem_d[head_q].valid = 1'b0;
    if (alloc_fire)
      mem_d[tail_q] = '{valid: 1'b1, done: 1'b0, rd_wen: rob.alloc_rd_wen, pd_old: rob.alloc_pd_old};
    head_d = head_q + TAG_W'(commit);
    tail_d = flush ? rob.b_done_tag + TAG_W'(1) : tail_q + TAG_W'(alloc_fire);
    count_d = flush ? {1'b0, b_off} + (TAG_W+1)'(1) - (TAG_W+1)'(commit)
                    : count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      mem_q <= mem_d;
    end
  end
  assign rob.alloc_tag_out = tail_q;
  assign rob.commit_valid_out = commit;
  assign rob.commit_tag_out = head_q;
  assign rob.commit_free_out = commit & head_e.rd_wen;
  assign rob.commit_pd_old = commit ? head_e.pd_old : '0;
  assign rob.curr_rob_tag = head_q;
  assign rob.empty_out = count_q == '0;
  assign rob.full_out = count_q[TAG_W];
`ifdef ROB_PERF_EN
  rob_perf_counters u_perf (
    .clk          (clk),
    .reset        (reset),
    .commit_i     (commit),
    .flush_i      (flush & reset),
    .commit_cnt_o (rob.perf_commit_cnt),
    .flush_cnt_o  (rob.perf_flush_cnt)
  );
`else
  assign rob.perf_commit_cnt = '0;
  assign rob.perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  reorder_buffer_if bus ();
  reorder_buffer dut (.clk(clk), .reset(reset), .rob(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic idle();
    bus.alloc_valid_in = 0;
    bus.alloc_pd_old = '0;
    bus.alloc_rd_wen = 0;
    bus.alu_done_valid = 0;
    bus.b_done_valid = 0;
    bus.mem_done_valid = 0;
    bus.alu_done_tag = '0;
    bus.b_done_tag = '0;
    bus.mem_done_tag = '0;
    bus.b_mispredict = 0;
  endtask
  task automatic do_reset();
    idle();
    reset = 0;
    tick();
    reset = 1;
    #1;
  endtask
  initial begin
    idle();
    tick();
    tick();
    chk("rst_empty", 32'(bus.empty_out), 1);
    chk("rst_ready", 32'(bus.alloc_ready_out), 0);
    chk("rst_head", 32'(bus.curr_rob_tag), 0);
    chk("rst_cvalid", 32'(bus.commit_valid_out), 0);
    chk("rst_full", 32'(bus.full_out), 0);
    chk("rst_atag", 32'(bus.alloc_tag_out), 0);
    chk("rst_pd", 32'(bus.commit_pd_old), 0);
    reset = 1;
    #1;
    chk("rel_ready", 32'(bus.alloc_ready_out), 1);
    // fill all 16 entries
    for (int i = 0; i < 16; i++) begin
      bus.alloc_valid_in = 1;
      bus.alloc_rd_wen = 1;
      bus.alloc_pd_old = 7'(i);
      #1;
      chk("fill_tag", 32'(bus.alloc_tag_out), 32'(i));
      tick();
    end
    chk("fill_full", 32'(bus.full_out), 1);
    chk("fill_ready", 32'(bus.alloc_ready_out), 0);
    chk("fill_atag", 32'(bus.alloc_tag_out), 0);
    tick();
    chk("blk_atag", 32'(bus.alloc_tag_out), 0);
    chk("blk_count", 32'(dut.count_q), 16);
    bus.alloc_valid_in = 0;
    bus.alu_done_valid = 1;
    bus.alu_done_tag = 0;
    tick();
    bus.alu_done_valid = 0;
    #1;
    chk("sim_cvalid", 32'(bus.commit_valid_out), 1);
    chk("sim_ctag", 32'(bus.commit_tag_out), 0);
    chk("sim_free", 32'(bus.commit_free_out), 1);
    bus.alloc_valid_in = 1;
    #1;
    chk("sim_ready", 32'(bus.alloc_ready_out), 0);
    tick();
    bus.alloc_valid_in = 0;
    chk("sim_count", 32'(dut.count_q), 15);
    chk("sim_head", 32'(bus.curr_rob_tag), 1);
    chk("sim_atag", 32'(bus.alloc_tag_out), 0);
    chk("sim_full", 32'(bus.full_out), 0);
    // reset mid-operation discards everything
    do_reset();
    chk("mid_empty", 32'(bus.empty_out), 1);
    chk("mid_head", 32'(bus.curr_rob_tag), 0);
    chk("mid_cvalid", 32'(bus.commit_valid_out), 0);
    // out-of-order completion
    for (int i = 0; i < 4; i++) begin
      bus.alloc_valid_in = 1;
      bus.alloc_rd_wen = (i != 1);
      bus.alloc_pd_old = 7'(10 + i);
      tick();
    end
    idle();
    bus.alu_done_valid = 1;
    bus.alu_done_tag = 2;
    tick();
    idle();
    bus.mem_done_valid = 1;
    bus.mem_done_tag = 3;
    tick();
    idle();
    #1;
    chk("ooo_wait", 32'(bus.commit_valid_out), 0);
    bus.b_done_valid = 1;
    bus.b_done_tag = 0;
    tick();
    idle();
    chk("ooo_c0", 32'(bus.commit_valid_out), 1);
    chk("ooo_t0", 32'(bus.commit_tag_out), 0);
    chk("ooo_p0", 32'(bus.commit_pd_old), 10);
    chk("ooo_f0", 32'(bus.commit_free_out), 1);
    bus.alu_done_valid = 1;
    bus.alu_done_tag = 1;
    tick();
    idle();
    #1;
    chk("ooo_c1", 32'(bus.commit_valid_out), 1);
    chk("ooo_t1", 32'(bus.commit_tag_out), 1);
    chk("ooo_p1", 32'(bus.commit_pd_old), 11);
    chk("ooo_f1", 32'(bus.commit_free_out), 0);
    tick();
    chk("ooo_t2", 32'(bus.commit_tag_out), 2);
    chk("ooo_p2", 32'(bus.commit_pd_old), 12);
    chk("ooo_c2", 32'(bus.commit_valid_out), 1);
    tick();
    chk("ooo_t3", 32'(bus.commit_tag_out), 3);
    chk("ooo_p3", 32'(bus.commit_pd_old), 13);
    chk("ooo_c3", 32'(bus.commit_valid_out), 1);
    tick();
    chk("ooo_empty", 32'(bus.empty_out), 1);
    chk("ooo_cend", 32'(bus.commit_valid_out), 0);
    // mispredict squash
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.alloc_valid_in = 1;
      bus.alloc_rd_wen = 1;
      bus.alloc_pd_old = 7'(20 + i);
      tick();
    end
    idle();
    bus.b_done_valid = 1;
    bus.b_mispredict = 1;
    bus.b_done_tag = 2;
    bus.alu_done_valid = 1;
    bus.alu_done_tag = 4;
    bus.alloc_valid_in = 1;
    #1;
    chk("mp_ready", 32'(bus.alloc_ready_out), 0);
    tick();
    idle();
    #1;
    chk("mp_count", 32'(dut.count_q), 3);
    chk("mp_atag", 32'(bus.alloc_tag_out), 3);
    chk("mp_cvalid", 32'(bus.commit_valid_out), 0);
    bus.alu_done_valid = 1;
    bus.alu_done_tag = 0;
    bus.mem_done_valid = 1;
    bus.mem_done_tag = 1;
    tick();
    idle();
    #1;
    chk("mp_c0", 32'(bus.commit_tag_out), 0);
    chk("mp_v0", 32'(bus.commit_valid_out), 1);
    tick();
    chk("mp_c1", 32'(bus.commit_tag_out), 1);
    chk("mp_v1", 32'(bus.commit_valid_out), 1);
    tick();
    chk("mp_c2", 32'(bus.commit_tag_out), 2);
    chk("mp_p2", 32'(bus.commit_pd_old), 22);
    chk("mp_v2", 32'(bus.commit_valid_out), 1);
    tick();
    chk("mp_empty", 32'(bus.empty_out), 1);
    bus.alloc_valid_in = 1;
    bus.alloc_pd_old = 7'd30;
    #1;
    chk("mp_realloc", 32'(bus.alloc_tag_out), 3);
    tick();
    idle();
    #1;
    chk("mp_fresh", 32'(bus.commit_valid_out), 0);
`ifdef ROB_PERF_EN
    chk("mp_perf", bus.perf_flush_cnt, 1);
`else
    chk("mp_perf", bus.perf_flush_cnt, 0);
`endif
    // wrap-around
    do_reset();
    for (int i = 0; i < 40; i++) begin
      bus.alloc_valid_in = 1;
      bus.alloc_rd_wen = 1;
      bus.alloc_pd_old = 7'(i);
      #1;
      chk("wr_atag", 32'(bus.alloc_tag_out), 32'(i % 16));
      tick();
      idle();
      bus.alu_done_valid = 1;
      bus.alu_done_tag = 4'(i % 16);
      tick();
      idle();
      #1;
      chk("wr_cv", 32'(bus.commit_valid_out), 1);
      chk("wr_ctag", 32'(bus.commit_tag_out), 32'(i % 16));
      chk("wr_pd", 32'(bus.commit_pd_old), 32'(i));
      tick();
    end
    chk("wr_empty", 32'(bus.empty_out), 1);
    chk("wr_head", 32'(bus.curr_rob_tag), 8);
`ifdef ROB_PERF_EN
    chk("wr_perf", bus.perf_commit_cnt, 40);
`else
    chk("wr_perf", bus.perf_commit_cnt, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
